vga_term_writer: RTL and testbench



---
 rtl/vga_term_pkg.sv | 34 +++
 rtl/vga_term_wbm.sv | 73 +++++++
 rtl/vga_term_writer.sv | 228 ++++++++++++++++++++++
 tb/tb_vga_term_writer.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_term_pkg.sv
// Shared constants, control codes, FSM state type and the cell address helper for vga_term_writer.
// All widths are explicit so that cursor and word arithmetic stays exact.
package vga_term_pkg;

  localparam logic [6:0]  COLS           = 7'd80;
  localparam logic [6:0]  LAST_COL       = COLS - 7'd1;
  localparam logic [4:0]  FIRST_ROW      = 5'd1;
  localparam logic [4:0]  LAST_ROW       = 5'd24;
  localparam logic [9:0]  ROW_WORDS      = 10'd40;
  localparam logic [9:0]  TXT_FIRST_WORD = 10'd40;
  localparam logic [9:0]  TXT_LAST_WORD  = 10'd999;
  localparam logic [9:0]  SCR_LAST_WORD  = TXT_LAST_WORD - ROW_WORDS;
  localparam logic [15:0] BLANK          = 16'h2020;

  localparam logic [7:0] CC_CR = 8'h0D;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_FF = 8'h0C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUT,
    ST_SCR_RD,
    ST_SCR_WR,
    ST_CLR,
    ST_GAP
  } state_t;

  // row*80 + col, built from shifts: row*64 + row*16 + col
  function automatic logic [10:0] cell_adr(input logic [4:0] row, input logic [6:0] col);
    return {row, 6'b0} + {2'b0, row, 4'b0} + {4'b0, col};
  endfunction

endpackage

// File: rtl/vga_term_wbm.sv
// Single Wishbone transaction engine: registered cyc/stb, held until ack, then one forced idle cycle.
// Latency: start sampled at edge A, ack sampled at A+1 against a 1-cycle slave; start is ignored unless idle.
module vga_term_wbm
  import vga_term_pkg::*;
#(
  parameter logic [15:0] VRAM_BASE = 16'h0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start,
  input  logic        we,
  input  logic [9:0]  word,
  input  logic        odd,
  input  logic [15:0] dat,
  input  logic [1:0]  sel,
  output logic        done,
  output logic        idle,
  output logic [15:0] rdata,
  output logic [15:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [1:0]  wb_sel_o,
  input  logic        wb_ack_i
);

  logic cyc;
  logic gap;

  assign done     = cyc & wb_ack_i;
  assign idle     = ~cyc & ~gap;
  assign wb_cyc_o = cyc;
  assign wb_stb_o = cyc;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cyc      <= 1'b0;
      gap      <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_sel_o <= 2'b00;
      wb_adr_o <= 16'h0000;
      wb_dat_o <= 16'h0000;
    end else begin
      gap <= done;
      if (done) begin
        cyc <= 1'b0;
      end else if (start && idle) begin
        cyc      <= 1'b1;
        wb_we_o  <= we;
        wb_sel_o <= sel;
        wb_adr_o <= VRAM_BASE + {5'd0, word, odd};
        wb_dat_o <= dat;
      end
    end
  end

`ifdef VGA_TERM_SCROLL_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rdata <= 16'h0000;
    end else if (done && !wb_we_o) begin
      rdata <= wb_dat_i;
    end
  end
`else
  logic unused_dat;
  assign unused_dat = ^wb_dat_i;
  assign rdata      = 16'h0000;
`endif

endmodule

// File: rtl/vga_term_writer.sv
// Character stream to 80x25 text buffer writer: cursor, CR/LF/BS/FF, scroll or row-1 wrap (VGA_TERM_SCROLL_EN).
// Latency: printable 3 cycles, CR/BS/LF 1 cycle; ch_ready is low for the whole of any bus sequence.
module vga_term_writer
  import vga_term_pkg::*;
#(
  parameter logic [15:0] VRAM_BASE = 16'h0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  ch_data,
  input  logic        ch_valid,
  output logic        ch_ready,
  output logic [15:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [1:0]  wb_sel_o,
  input  logic        wb_ack_i,
  output logic [10:0] cursor,
  output logic        busy
);

  // What happens when the row advances past the last text row
`ifdef VGA_TERM_SCROLL_EN
  localparam state_t      OVF_STATE   = ST_SCR_RD;
  localparam logic [4:0]  OVF_ROW     = LAST_ROW;
  localparam logic [9:0]  OVF_CLR_END = TXT_LAST_WORD;
`else
  localparam state_t      OVF_STATE   = ST_CLR;
  localparam logic [4:0]  OVF_ROW     = FIRST_ROW;
  localparam logic [9:0]  OVF_CLR_END = TXT_FIRST_WORD + ROW_WORDS - 10'd1;
`endif

  state_t      state, state_nx, after, after_nx;
  logic [4:0]  crow, nrow, nrow_nx;
  logic [6:0]  ccol, ncol, ncol_nx;
  logic [9:0]  widx, widx_nx, clr_end, clr_end_nx;
  logic        ovf, ovf_nx;
  logic [7:0]  ch, ch_nx;

  logic        start, we, odd, done, idle;
  logic [9:0]  word;
  logic [15:0] dat, rdata;
  logic [1:0]  sel;

  assign cursor   = cell_adr(crow, ccol);
  assign ch_ready = (state == ST_IDLE);
  assign busy     = ~ch_ready;

  always_comb begin
    state_nx   = state;
    after_nx   = after;
    nrow_nx    = nrow;
    ncol_nx    = ncol;
    widx_nx    = widx;
    clr_end_nx = clr_end;
    ovf_nx     = ovf;
    ch_nx      = ch;
    start      = 1'b0;
    we         = 1'b1;
    word       = widx;
    odd        = 1'b0;
    dat        = BLANK;
    sel        = 2'b11;

    case (state)
      ST_IDLE: begin
        if (ch_valid) begin
          ch_nx   = ch_data;
          nrow_nx = crow;
          ncol_nx = ccol;
          ovf_nx  = 1'b0;
          after_nx = ST_IDLE;
          case (ch_data)
            CC_CR: begin
              ncol_nx  = 7'd0;
              state_nx = ST_GAP;
            end
            CC_BS: begin
              if (ccol != 7'd0) ncol_nx = ccol - 7'd1;
              state_nx = ST_GAP;
            end
            CC_LF: begin
              if (crow < LAST_ROW) begin
                nrow_nx  = crow + 5'd1;
                state_nx = ST_GAP;
              end else begin
                nrow_nx    = OVF_ROW;
                widx_nx    = TXT_FIRST_WORD;
                clr_end_nx = OVF_CLR_END;
                state_nx   = OVF_STATE;
              end
            end
            CC_FF: begin
              nrow_nx    = FIRST_ROW;
              ncol_nx    = 7'd0;
              widx_nx    = TXT_FIRST_WORD;
              clr_end_nx = TXT_LAST_WORD;
              state_nx   = ST_CLR;
            end
            default: begin
              state_nx = ST_PUT;
              if (ccol == LAST_COL) begin
                ncol_nx = 7'd0;
                if (crow < LAST_ROW) begin
                  nrow_nx = crow + 5'd1;
                end else begin
                  nrow_nx = OVF_ROW;
                  ovf_nx  = 1'b1;
                end
              end else begin
                ncol_nx = ccol + 7'd1;
              end
            end
          endcase
        end
      end

      ST_PUT: begin
        start = idle;
        word  = cursor[10:1];
        odd   = cursor[0];
        dat   = {ch, ch};
        sel   = cursor[0] ? 2'b10 : 2'b01;
        if (done) begin
          state_nx   = ST_GAP;
          after_nx   = ovf ? OVF_STATE : ST_IDLE;
          widx_nx    = TXT_FIRST_WORD;
          clr_end_nx = OVF_CLR_END;
        end
      end

`ifdef VGA_TERM_SCROLL_EN
      ST_SCR_RD: begin
        start = idle;
        we    = 1'b0;
        word  = widx + ROW_WORDS;
        if (done) begin
          state_nx = ST_GAP;
          after_nx = ST_SCR_WR;
        end
      end

      ST_SCR_WR: begin
        start = idle;
        dat   = rdata;
        if (done) begin
          state_nx = ST_GAP;
          after_nx = (widx == SCR_LAST_WORD) ? ST_CLR : ST_SCR_RD;
          widx_nx  = widx + 10'd1;
        end
      end
`endif

      ST_CLR: begin
        start = idle;
        if (done) begin
          state_nx = ST_GAP;
          after_nx = (widx == clr_end) ? ST_IDLE : ST_CLR;
          widx_nx  = widx + 10'd1;
        end
      end

      ST_GAP: state_nx = after;

      default: state_nx = ST_CLR;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state   <= ST_CLR;
      after   <= ST_IDLE;
      crow    <= FIRST_ROW;
      ccol    <= 7'd0;
      nrow    <= FIRST_ROW;
      ncol    <= 7'd0;
      widx    <= TXT_FIRST_WORD;
      clr_end <= TXT_LAST_WORD;
      ovf     <= 1'b0;
      ch      <= 8'h00;
    end else begin
      state   <= state_nx;
      after   <= after_nx;
      nrow    <= nrow_nx;
      ncol    <= ncol_nx;
      widx    <= widx_nx;
      clr_end <= clr_end_nx;
      ovf     <= ovf_nx;
      ch      <= ch_nx;
      // The visible cursor moves only as the FSM re-enters IDLE
      if (state == ST_GAP && after == ST_IDLE) begin
        crow <= nrow;
        ccol <= ncol;
      end
    end
  end

`ifndef VGA_TERM_SCROLL_EN
  logic unused_rdata;
  assign unused_rdata = ^rdata;
`endif

  vga_term_wbm #(.VRAM_BASE(VRAM_BASE)) u_wbm (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .start    (start),
    .we       (we),
    .word     (word),
    .odd      (odd),
    .dat      (dat),
    .sel      (sel),
    .done     (done),
    .idle     (idle),
    .rdata    (rdata),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_sel_o (wb_sel_o),
    .wb_ack_i (wb_ack_i)
  );

endmodule

// File: tb/tb_vga_term_writer.sv
// Directed bench for vga_term_writer with a 1-cycle-ack video memory model and a bus transaction log.
`timescale 1ns/1ps
module tb_vga_term_writer;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [7:0]  ch_data  = 8'h00;
  logic        ch_valid = 1'b0;
  logic        ch_ready;
  logic [15:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
  logic [1:0]  wb_sel_o;
  logic [10:0] cursor;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [0:1023];
  logic [15:0] log_adr [$];
  logic [15:0] log_dat [$];
  logic [1:0]  log_sel [$];
  logic        log_we  [$];

  always #5 wb_clk_i = ~wb_clk_i;

  assign wb_ack_i = wb_cyc_o & wb_stb_o;
  assign wb_dat_i = mem[wb_adr_o[10:1]];

  vga_term_writer dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .ch_data  (ch_data),
    .ch_valid (ch_valid),
    .ch_ready (ch_ready),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_sel_o (wb_sel_o),
    .wb_ack_i (wb_ack_i),
    .cursor   (cursor),
    .busy     (busy)
  );

  // Each transaction is high for exactly one cycle against this slave
  always @(negedge wb_clk_i) begin
    if (wb_cyc_o && wb_stb_o && !wb_rst_i) begin
      log_adr.push_back(wb_adr_o);
      log_dat.push_back(wb_dat_o);
      log_sel.push_back(wb_sel_o);
      log_we.push_back(wb_we_o);
      if (wb_we_o) begin
        if (wb_sel_o[0]) mem[wb_adr_o[10:1]][7:0]  = wb_dat_o[7:0];
        if (wb_sel_o[1]) mem[wb_adr_o[10:1]][15:8] = wb_dat_o[15:8];
      end
    end
  end

  task automatic clear_log();
    log_adr.delete();
    log_dat.delete();
    log_sel.delete();
    log_we.delete();
  endtask

  task automatic wait_ready(input int budget, output int cycles);
    cycles = 0;
    @(negedge wb_clk_i);
    while (!ch_ready && cycles <= budget) begin
      cycles++;
      @(negedge wb_clk_i);
    end
    if (!ch_ready) begin
      total++;
      bad++;
      $display("FAIL wait_ready: ch_ready=%b after %0d cycles, required 1", ch_ready, cycles);
    end
  endtask

  task automatic send(input logic [7:0] c);
    int cy;
    if (!ch_ready) wait_ready(8000, cy);
    ch_data  = c;
    ch_valid = 1'b1;
    @(posedge wb_clk_i);
    #1;
    ch_valid = 1'b0;
    ch_data  = 8'h00;
  endtask

  task automatic send_wait(input logic [7:0] c, output int cy);
    send(c);
    wait_ready(8000, cy);
  endtask

  task automatic goto_last_row();
    int cy;
    int g = 0;
    while (cursor < 11'd1920 && g < 30) begin
      send_wait(8'h0A, cy);
      g++;
    end
  endtask

  task automatic test_reset();
    int cy;
    int errs = 0;
    wb_rst_i = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    total++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, ch_ready, busy} !== 7'b0000001) begin
      bad++;
      $display("FAIL reset_ctrl: cyc/stb/we/sel/rdy/busy=%b required 0000001",
               {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, ch_ready, busy});
    end
    total++;
    if ({wb_adr_o, wb_dat_o} !== 32'h0) begin
      bad++;
      $display("FAIL reset_bus: adr=%h dat=%h required 0000 0000", wb_adr_o, wb_dat_o);
    end
    total++;
    if (cursor !== 11'd80) begin
      bad++;
      $display("FAIL reset_cursor: got %0d required 80", cursor);
    end
    clear_log();
    wb_rst_i = 1'b0;
    wait_ready(4000, cy);
    total++;
    if (log_adr.size() != 960) begin
      bad++;
      $display("FAIL poweron_count: got %0d writes required 960", log_adr.size());
    end
    foreach (log_adr[i]) begin
      if (log_adr[i] !== 16'(80 + 2 * i) || log_dat[i] !== 16'h2020 ||
          log_sel[i] !== 2'b11 || log_we[i] !== 1'b1) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL poweron_content: %0d bad writes, required 0", errs);
    end
    total++;
    if (cursor !== 11'd80 || busy !== 1'b0) begin
      bad++;
      $display("FAIL poweron_end: cursor=%0d busy=%b required 80 0", cursor, busy);
    end
  endtask

  task automatic test_put();
    int cy;
    clear_log();
    send_wait(8'h41, cy);
    total++;
    if (cy != 3) begin
      bad++;
      $display("FAIL put_latency: got %0d cycles required 3", cy);
    end
    send_wait(8'h42, cy);
    total++;
    if (log_adr.size() != 2) begin
      bad++;
      $display("FAIL put_count: got %0d writes required 2", log_adr.size());
    end else begin
      total++;
      if ({log_adr[0], log_sel[0], log_dat[0], log_we[0]} !== {16'd80, 2'b01, 16'h4141, 1'b1}) begin
        bad++;
        $display("FAIL put_a: adr=%0d sel=%b dat=%h we=%b required 80 01 4141 1",
                 log_adr[0], log_sel[0], log_dat[0], log_we[0]);
      end
      total++;
      if ({log_adr[1], log_sel[1], log_dat[1], log_we[1]} !== {16'd81, 2'b10, 16'h4242, 1'b1}) begin
        bad++;
        $display("FAIL put_b: adr=%0d sel=%b dat=%h we=%b required 81 10 4242 1",
                 log_adr[1], log_sel[1], log_dat[1], log_we[1]);
      end
    end
    total++;
    if (cursor !== 11'd82) begin
      bad++;
      $display("FAIL put_cursor: got %0d required 82", cursor);
    end
  endtask

  task automatic test_busy_ignore();
    int cy;
    clear_log();
    send(8'h43);
    ch_data  = 8'h5A;
    ch_valid = 1'b1;
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    ch_valid = 1'b0;
    ch_data  = 8'h00;
    wait_ready(20, cy);
    repeat (4) @(negedge wb_clk_i);
    total++;
    if (log_adr.size() != 1 || log_dat[0] !== 16'h4343 || log_adr[0] !== 16'd82) begin
      bad++;
      $display("FAIL busy_ignore: writes=%0d first adr=%0d dat=%h required 1 82 4343",
               log_adr.size(), log_adr[0], log_dat[0]);
    end
    total++;
    if (cursor !== 11'd83) begin
      bad++;
      $display("FAIL busy_cursor: got %0d required 83", cursor);
    end
  endtask

  task automatic test_line_wrap();
    int cy;
    int n;
    for (int i = 0; i < 77; i++) send_wait(8'h61 + 8'(i % 26), cy);
    n = log_adr.size();
    total++;
    if (log_adr[n-1] !== 16'd159 || log_sel[n-1] !== 2'b10 || cursor !== 11'd160) begin
      bad++;
      $display("FAIL wrap_col79: adr=%0d sel=%b cursor=%0d required 159 10 160",
               log_adr[n-1], log_sel[n-1], cursor);
    end
    clear_log();
    send_wait(8'h58, cy);
    total++;
    if (log_adr.size() != 1 || log_adr[0] !== 16'd160 || log_sel[0] !== 2'b01 ||
        log_dat[0] !== 16'h5858 || cursor !== 11'd161) begin
      bad++;
      $display("FAIL wrap_x: adr=%0d sel=%b dat=%h cursor=%0d required 160 01 5858 161",
               log_adr[0], log_sel[0], log_dat[0], cursor);
    end
    send_wait(8'h0D, cy);
    total++;
    if (cy != 1 || cursor !== 11'd160) begin
      bad++;
      $display("FAIL cr: latency=%0d cursor=%0d required 1 160", cy, cursor);
    end
    send_wait(8'h08, cy);
    total++;
    if (cy != 1 || cursor !== 11'd160) begin
      bad++;
      $display("FAIL bs_col0: latency=%0d cursor=%0d required 1 160", cy, cursor);
    end
    send_wait(8'h51, cy);
    send_wait(8'h51, cy);
    clear_log();
    send_wait(8'h08, cy);
    total++;
    if (cy != 1 || cursor !== 11'd161 || log_adr.size() != 0) begin
      bad++;
      $display("FAIL bs_mid: latency=%0d cursor=%0d writes=%0d required 1 161 0",
               cy, cursor, log_adr.size());
    end
    send_wait(8'h0A, cy);
    total++;
    if (cy != 1 || cursor !== 11'd241) begin
      bad++;
      $display("FAIL lf_mid: latency=%0d cursor=%0d required 1 241", cy, cursor);
    end
  endtask

  task automatic test_row_overflow();
    int cy;
    int errs = 0;
    goto_last_row();
    send_wait(8'h0D, cy);
    send_wait(8'h4B, cy);
    for (int i = 0; i < 40; i++) begin
      mem[40 + i] = 16'h1100 + 16'(i);
      mem[80 + i] = 16'hA000 + 16'(i);
    end
    mem[999] = 16'h5555;
    clear_log();
    send_wait(8'h0A, cy);
`ifdef VGA_TERM_SCROLL_EN
    total++;
    if (cy != 5640) begin
      bad++;
      $display("FAIL scroll_latency: got %0d cycles required 5640", cy);
    end
    total++;
    if (mem[40] !== 16'hA000) begin
      bad++;
      $display("FAIL scroll_word40: got %h required a000", mem[40]);
    end
    for (int i = 0; i < 40; i++) begin
      if (mem[40 + i] !== 16'hA000 + 16'(i)) errs++;
      if (mem[960 + i] !== 16'h2020) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL scroll_content: %0d bad words, required 0", errs);
    end
    total++;
    if (log_adr.size() != 1880 || cursor !== 11'd1921) begin
      bad++;
      $display("FAIL scroll_end: txns=%0d cursor=%0d required 1880 1921", log_adr.size(), cursor);
    end
`else
    total++;
    if (cy != 120) begin
      bad++;
      $display("FAIL wrap_clear_latency: got %0d cycles required 120", cy);
    end
    for (int i = 0; i < 40; i++) if (mem[40 + i] !== 16'h2020) errs++;
    total++;
    if (errs != 0 || mem[80] !== 16'hA000 || mem[999] !== 16'h5555) begin
      bad++;
      $display("FAIL wrap_clear_content: bad=%0d w80=%h w999=%h required 0 a000 5555",
               errs, mem[80], mem[999]);
    end
    total++;
    if (log_adr.size() != 40 || cursor !== 11'd81) begin
      bad++;
      $display("FAIL wrap_clear_end: txns=%0d cursor=%0d required 40 81", log_adr.size(), cursor);
    end
`endif
  endtask

  task automatic test_corner();
    int cy;
    int g = 0;
    goto_last_row();
    while (cursor % 80 != 79 && g < 100) begin
      send_wait(8'h79, cy);
      g++;
    end
    clear_log();
    send_wait(8'h45, cy);
    total++;
    if (log_adr.size() == 0 || log_adr[0] !== 16'd1999 || log_sel[0] !== 2'b10 ||
        log_dat[0] !== 16'h4545) begin
      bad++;
      $display("FAIL corner_put: adr=%0d sel=%b dat=%h required 1999 10 4545",
               log_adr[0], log_sel[0], log_dat[0]);
    end
`ifdef VGA_TERM_SCROLL_EN
    total++;
    if (cy != 5643 || cursor !== 11'd1920) begin
      bad++;
      $display("FAIL corner_end: latency=%0d cursor=%0d required 5643 1920", cy, cursor);
    end
`else
    total++;
    if (cy != 123 || cursor !== 11'd80) begin
      bad++;
      $display("FAIL corner_end: latency=%0d cursor=%0d required 123 80", cy, cursor);
    end
`endif
  endtask

  task automatic test_ff();
    int cy;
    int errs = 0;
    send_wait(8'h6D, cy);
    send_wait(8'h6E, cy);
    clear_log();
    send_wait(8'h0C, cy);
    foreach (log_adr[i]) begin
      if (log_adr[i] !== 16'(80 + 2 * i) || log_dat[i] !== 16'h2020 || log_sel[i] !== 2'b11) errs++;
    end
    total++;
    if (cy != 2880 || log_adr.size() != 960 || errs != 0) begin
      bad++;
      $display("FAIL ff_clear: latency=%0d writes=%0d bad=%0d required 2880 960 0",
               cy, log_adr.size(), errs);
    end
    total++;
    if (cursor !== 11'd80) begin
      bad++;
      $display("FAIL ff_cursor: got %0d required 80", cursor);
    end
  endtask

  task automatic test_reset_mid();
    int cy;
    int n = 0;
    goto_last_row();
    send(8'h0A);
    while (!(wb_cyc_o && wb_we_o) && n < 50) begin
      @(negedge wb_clk_i);
      n++;
    end
    total++;
    if (!(wb_cyc_o && wb_we_o)) begin
      bad++;
      $display("FAIL rst_mid_find: no write cycle within %0d cycles", n);
    end
    wb_rst_i = 1'b1;
    #1;
    total++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || ch_ready !== 1'b0 || cursor !== 11'd80) begin
      bad++;
      $display("FAIL rst_mid_drop: cyc=%b stb=%b rdy=%b cursor=%0d required 0 0 0 80",
               wb_cyc_o, wb_stb_o, ch_ready, cursor);
    end
    @(negedge wb_clk_i);
    clear_log();
    wb_rst_i = 1'b0;
    wait_ready(4000, cy);
    total++;
    if (log_adr.size() != 960 || log_adr[0] !== 16'd80 || log_dat[0] !== 16'h2020) begin
      bad++;
      $display("FAIL rst_mid_restart: writes=%0d first adr=%0d dat=%h required 960 80 2020",
               log_adr.size(), log_adr[0], log_dat[0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    test_reset();
    test_put();
    test_busy_ignore();
    test_line_wrap();
    test_row_overflow();
    test_corner();
    test_ff();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
